// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED fade/PWM stage.
package led_pkg;

   localparam int LED_N        = 8;
   localparam int PWM_BITS_DEF = 8;

   function automatic int pwm_max(input int bits);
      return (1 << bits) - 1;
   endfunction

   // Pin level that leaves every LED dark for the given output polarity.
   function automatic logic [LED_N:1] inactive_level(input bit active_low);
      return active_low ? {LED_N{1'b1}} : {LED_N{1'b0}};
   endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level with set/fade, period-latched shadow and PWM compare.
module led_pwm_channel
   import led_pkg::*;
#(
   parameter int PWM_BITS  = PWM_BITS_DEF,
   parameter int FADE_STEP = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable_i,
   input  logic                set_i,
   input  logic                fade_tick_i,
   input  logic                shadow_load_i,
   input  logic [PWM_BITS-1:0] pwm_cnt_i,
   output logic [PWM_BITS-1:0] level_o,
   output logic                on_o
);

   localparam logic [PWM_BITS-1:0] MAX  = PWM_BITS'(pwm_max(PWM_BITS));
   localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(FADE_STEP);

   logic [PWM_BITS-1:0] level_q, level_d;
   logic [PWM_BITS-1:0] shadow_q, shadow_d;

   // A lit input always wins over a coincident fade tick.
   always_comb begin
      level_d = level_q;
      if (!enable_i)
         level_d = '0;
      else if (set_i)
         level_d = MAX;
      else if (fade_tick_i)
         level_d = (int'(level_q) > FADE_STEP) ? level_q - STEP : '0;
      shadow_d = shadow_load_i ? level_q : shadow_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q  <= '0;
         shadow_q <= '0;
      end else begin
         level_q  <= level_d;
         shadow_q <= shadow_d;
      end
   end

   assign level_o = level_q;
   assign on_o    = shadow_q > pwm_cnt_i;

endmodule

// File: rtl/led_fade_pwm.sv
// Comet-tail LED driver: per-LED PWM whose brightness jumps to full on a lit input
// and decays linearly once the chaser moves on.
module led_fade_pwm
   import led_pkg::*;
#(
   parameter int PWM_BITS       = PWM_BITS_DEF,
   parameter int FADE_DIV       = 195312,
   parameter int FADE_STEP      = 4,
   parameter bit OUT_ACTIVE_LOW = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [LED_N:1]   led_in,
   output logic [LED_N:1]   led_out,
   output logic             busy
);

   localparam int                  MAXV      = pwm_max(PWM_BITS);
   localparam int                  TICK_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
   localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(FADE_DIV - 1);
   localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'(MAXV - 1);
   localparam logic [LED_N:1]      INACTIVE  = inactive_level(OUT_ACTIVE_LOW);

   logic [LED_N:1]      led_q;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [LED_N:1]      led_out_q, led_out_d;
   logic                busy_q, busy_d;

   logic                fade_tick;
   logic                period_end;
   logic [LED_N:1]      on;
   logic [LED_N:1]      nz;
   logic [PWM_BITS-1:0] level [LED_N:1];

   assign fade_tick  = tick_cnt_q == TICK_LAST;
   assign period_end = pwm_cnt_q == PWM_LAST;

   // Both counters free-run; enable and led_in only gate the channels.
   always_comb begin
      tick_cnt_d = fade_tick  ? '0 : tick_cnt_q + 1'b1;
      pwm_cnt_d  = period_end ? '0 : pwm_cnt_q + 1'b1;
      led_out_d  = enable ? (on ^ INACTIVE) : INACTIVE;
      busy_d     = |nz;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q      <= '0;
         tick_cnt_q <= '0;
         pwm_cnt_q  <= '0;
         led_out_q  <= INACTIVE;
         busy_q     <= 1'b0;
      end else begin
         led_q      <= led_in;
         tick_cnt_q <= tick_cnt_d;
         pwm_cnt_q  <= pwm_cnt_d;
         led_out_q  <= led_out_d;
         busy_q     <= busy_d;
      end
   end

   for (genvar i = 1; i <= LED_N; i++) begin : g_ch
      led_pwm_channel #(
         .PWM_BITS  (PWM_BITS),
         .FADE_STEP (FADE_STEP)
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .enable_i      (enable),
         .set_i         (led_q[i]),
         .fade_tick_i   (fade_tick),
         .shadow_load_i (period_end),
         .pwm_cnt_i     (pwm_cnt_q),
         .level_o       (level[i]),
         .on_o          (on[i])
      );
      assign nz[i] = |level[i];
   end

   assign led_out = led_out_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: two fast-fade instances (both polarities) against a cycle model,
// plus a slow-fade instance whose per-period duty is checked against the fade arithmetic.
module tb_led_fade_pwm;

   localparam int FD   = 4;
   localparam int STEP = 64;
   localparam int MAXV = 255;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [8:1] led_in;
   logic [8:1] out_a, out_b, out_c;
   logic       busy_a, busy_b, busy_c;

   int vectors     = 0;
   int miscompares = 0;

   logic [8:1] m_led_q, m_out;
   logic       m_busy;
   int         m_tick, m_pwm;
   int         m_lvl [1:8];
   int         m_shd [1:8];

   always #5 clk = ~clk;

   led_fade_pwm #(.FADE_DIV(FD), .FADE_STEP(STEP), .OUT_ACTIVE_LOW(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .led_in(led_in), .led_out(out_a), .busy(busy_a));
   led_fade_pwm #(.FADE_DIV(FD), .FADE_STEP(STEP), .OUT_ACTIVE_LOW(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(enable), .led_in(led_in), .led_out(out_b), .busy(busy_b));
   led_fade_pwm #(.FADE_DIV(MAXV), .FADE_STEP(STEP), .OUT_ACTIVE_LOW(1'b0)) dut_c (
      .clk(clk), .rst_n(rst_n), .enable(enable), .led_in(led_in), .led_out(out_c), .busy(busy_c));

   task automatic model_reset();
      m_led_q = '0;
      m_out   = '0;
      m_busy  = 1'b0;
      m_tick  = 0;
      m_pwm   = 0;
      for (int i = 1; i <= 8; i++) begin
         m_lvl[i] = 0;
         m_shd[i] = 0;
      end
   endtask

   // Advance one clock: apply the brightness rules to the model at the edge, return at negedge.
   task automatic step();
      bit ft;
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
         ft     = (m_tick == FD - 1);
         m_busy = 1'b0;
         for (int i = 1; i <= 8; i++) begin
            m_out[i] = enable && (m_shd[i] > m_pwm);
            if (m_lvl[i] != 0) m_busy = 1'b1;
            if (m_pwm == MAXV - 1) m_shd[i] = m_lvl[i];
            if (!enable)          m_lvl[i] = 0;
            else if (m_led_q[i])  m_lvl[i] = MAXV;
            else if (ft)          m_lvl[i] = (m_lvl[i] > STEP) ? m_lvl[i] - STEP : 0;
         end
         m_led_q = led_in;
         m_tick  = (m_tick + 1) % FD;
         m_pwm   = (m_pwm + 1) % MAXV;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b1; led_in = '0;
      model_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if (out_a !== 8'h00 || out_b !== 8'hFF || out_c !== 8'h00 || {busy_a, busy_b, busy_c} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_state out_a=%h out_b=%h out_c=%h busy=%b%b%b, expected 00/ff/00 busy=000",
                  out_a, out_b, out_c, busy_a, busy_b, busy_c);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         vectors++;
         if (out_a !== m_out || out_b !== ~m_out || busy_a !== m_busy || busy_b !== m_busy) begin
            miscompares++;
            $display("FAIL post_reset t=%0t out_a=%h out_b=%h busy=%b%b, expected out=%h busy=%b",
                     $time, out_a, out_b, busy_a, busy_b, m_out, m_busy);
         end
      end
   endtask

   task automatic test_async_reset();
      led_in = 8'hFF;
      for (int k = 0; k < 300; k++) begin
         step();
         vectors++;
         if (out_a !== m_out || out_b !== ~m_out || busy_a !== m_busy || busy_b !== m_busy) begin
            miscompares++;
            $display("FAIL pre_reset_fill t=%0t out_a=%h out_b=%h busy=%b%b, expected out=%h busy=%b",
                     $time, out_a, out_b, busy_a, busy_b, m_out, m_busy);
         end
      end
      vectors++;
      if (out_a !== 8'hFF) begin
         miscompares++;
         $display("FAIL full_on_before_reset out_a=%h, expected ff", out_a);
      end
      led_in = 8'h00;
      repeat (6) step();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (out_a !== 8'h00 || out_b !== 8'hFF || out_c !== 8'h00 || {busy_a, busy_b, busy_c} !== 3'b000) begin
         miscompares++;
         $display("FAIL async_reset out_a=%h out_b=%h out_c=%h busy=%b%b%b, expected 00/ff/00 busy=000",
                  out_a, out_b, out_c, busy_a, busy_b, busy_c);
      end
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 300; k++) begin
         step();
         vectors++;
         if (out_a !== m_out || out_b !== ~m_out || busy_a !== m_busy || busy_b !== m_busy
             || out_c !== 8'h00 || busy_c !== 1'b0) begin
            miscompares++;
            $display("FAIL no_tail_after_reset t=%0t out_a=%h out_b=%h out_c=%h busy=%b%b%b, expected out=%h busy=%b c=00/0",
                     $time, out_a, out_b, out_c, busy_a, busy_b, busy_c, m_out, m_busy);
         end
      end
   endtask

   task automatic test_single_on();
      led_in = 8'h01;
      for (int k = 0; k < 2 + MAXV + 1; k++) begin
         step();
         vectors++;
         if (out_a !== m_out || out_b !== ~m_out || busy_a !== m_busy || busy_b !== m_busy) begin
            miscompares++;
            $display("FAIL single_rise t=%0t out_a=%h out_b=%h busy=%b%b, expected out=%h busy=%b",
                     $time, out_a, out_b, busy_a, busy_b, m_out, m_busy);
         end
      end
      for (int k = 0; k < MAXV; k++) begin
         step();
         vectors++;
         if (out_a !== 8'h01 || out_b !== 8'hFE || busy_a !== 1'b1 || busy_b !== 1'b1) begin
            miscompares++;
            $display("FAIL single_full_on t=%0t out_a=%h out_b=%h busy=%b%b, expected 01/fe busy=11",
                     $time, out_a, out_b, busy_a, busy_b);
         end
      end
   endtask

   task automatic test_fade_periods();
      int cnt;
      int exp_cnt;
      bit exp_busy;
      led_in = 8'h01;
      for (int k = 0; k < 600; k++) begin
         step();
         vectors++;
         if (out_a !== m_out || out_b !== ~m_out || busy_a !== m_busy || busy_b !== m_busy) begin
            miscompares++;
            $display("FAIL fade_fill t=%0t out_a=%h out_b=%h busy=%b%b, expected out=%h busy=%b",
                     $time, out_a, out_b, busy_a, busy_b, m_out, m_busy);
         end
      end
      for (int g = 0; g < MAXV && m_pwm != 0; g++) step();
      led_in = 8'h00;
      for (int w = 0; w < 8; w++) begin
         cnt = 0;
         for (int k = 0; k < MAXV; k++) begin
            step();
            if (out_c[1]) cnt++;
            vectors++;
            if (out_a !== m_out || out_b !== ~m_out || busy_a !== m_busy || busy_b !== m_busy) begin
               miscompares++;
               $display("FAIL fade_fast t=%0t out_a=%h out_b=%h busy=%b%b, expected out=%h busy=%b",
                        $time, out_a, out_b, busy_a, busy_b, m_out, m_busy);
            end
         end
         // One fade tick per PWM period: duty follows 255,191,127,63,0 one period behind the level.
         exp_cnt  = (w <= 1) ? MAXV : ((MAXV - STEP * (w - 1) > 0) ? MAXV - STEP * (w - 1) : 0);
         exp_busy = (MAXV - STEP * w) > 0;
         vectors++;
         if (cnt != exp_cnt || busy_c !== exp_busy) begin
            miscompares++;
            $display("FAIL fade_period w=%0d high=%0d busy=%b, expected high=%0d busy=%b",
                     w, cnt, busy_c, exp_cnt, exp_busy);
         end
      end
   endtask

   task automatic test_set_wins();
      int cnt;
      led_in = 8'h00;
      for (int g = 0; g < MAXV && m_pwm != MAXV - 2; g++) step();
      led_in = 8'h04;
      step();
      led_in = 8'h00;
      step();
      for (int w = 0; w < 2; w++) begin
         cnt = 0;
         for (int k = 0; k < MAXV; k++) begin
            step();
            if (out_c[3]) cnt++;
         end
         vectors++;
         if (cnt != ((w == 0) ? 0 : MAXV)) begin
            miscompares++;
            $display("FAIL set_wins_period w=%0d high=%0d, expected %0d", w, cnt, (w == 0) ? 0 : MAXV);
         end
      end
      for (int k = 0; k < 40; k++) begin
         step();
         vectors++;
         if (out_a !== m_out || out_b !== ~m_out || busy_a !== m_busy || busy_b !== m_busy) begin
            miscompares++;
            $display("FAIL set_wins_settle t=%0t out_a=%h out_b=%h busy=%b%b, expected out=%h busy=%b",
                     $time, out_a, out_b, busy_a, busy_b, m_out, m_busy);
         end
      end
      for (int g = 0; g < FD && m_tick != 2; g++) step();
      led_in = 8'h04;
      step();
      led_in = 8'h00;
      step();
      vectors++;
      if (busy_a !== 1'b0) begin
         miscompares++;
         $display("FAIL set_tick_busy_lag busy_a=%b, expected 0", busy_a);
      end
      step();
      vectors++;
      if (busy_a !== 1'b1) begin
         miscompares++;
         $display("FAIL set_wins_tick busy_a=%b, expected 1", busy_a);
      end
      for (int k = 0; k < 30; k++) begin
         step();
         vectors++;
         if (out_a !== m_out || out_b !== ~m_out || busy_a !== m_busy || busy_b !== m_busy) begin
            miscompares++;
            $display("FAIL set_wins_decay t=%0t out_a=%h out_b=%h busy=%b%b, expected out=%h busy=%b",
                     $time, out_a, out_b, busy_a, busy_b, m_out, m_busy);
         end
      end
   endtask

   task automatic test_chaser();
      logic [8:1] pat;
      pat = 8'hFF;
      for (int s = 0; s < 9; s++) begin
         led_in = pat;
         for (int k = 0; k < 8 * FD; k++) begin
            step();
            vectors++;
            if (out_a !== m_out || out_b !== ~m_out || busy_a !== m_busy || busy_b !== m_busy) begin
               miscompares++;
               $display("FAIL chaser t=%0t out_a=%h out_b=%h busy=%b%b, expected out=%h busy=%b",
                        $time, out_a, out_b, busy_a, busy_b, m_out, m_busy);
            end
         end
         vectors++;
         if (busy_a !== (pat != 8'h00)) begin
            miscompares++;
            $display("FAIL chaser_busy pat=%h busy_a=%b, expected %b", pat, busy_a, pat != 8'h00);
         end
         pat = pat << 1;
      end
   endtask

   task automatic test_enable();
      enable = 1'b1;
      led_in = 8'hFF;
      for (int k = 0; k < 300; k++) begin
         step();
         vectors++;
         if (out_a !== m_out || out_b !== ~m_out || busy_a !== m_busy || busy_b !== m_busy) begin
            miscompares++;
            $display("FAIL enable_fill t=%0t out_a=%h out_b=%h busy=%b%b, expected out=%h busy=%b",
                     $time, out_a, out_b, busy_a, busy_b, m_out, m_busy);
         end
      end
      vectors++;
      if (out_a !== 8'hFF || out_b !== 8'h00 || out_c !== 8'hFF) begin
         miscompares++;
         $display("FAIL enable_full_on out_a=%h out_b=%h out_c=%h, expected ff/00/ff", out_a, out_b, out_c);
      end
      enable = 1'b0;
      step();
      vectors++;
      if (out_a !== 8'h00 || out_b !== 8'hFF || out_c !== 8'h00) begin
         miscompares++;
         $display("FAIL disable_dark out_a=%h out_b=%h out_c=%h, expected 00/ff/00", out_a, out_b, out_c);
      end
      step();
      vectors++;
      if ({busy_a, busy_b, busy_c} !== 3'b000) begin
         miscompares++;
         $display("FAIL disable_busy busy=%b%b%b, expected 000", busy_a, busy_b, busy_c);
      end
      for (int k = 0; k < 320; k++) begin
         if (k == 20) begin
            enable = 1'b1;
            led_in = 8'h00;
         end
         step();
         vectors++;
         if (out_a !== m_out || out_b !== ~m_out || busy_a !== m_busy || busy_b !== m_busy) begin
            miscompares++;
            $display("FAIL reenable t=%0t out_a=%h out_b=%h busy=%b%b, expected out=%h busy=%b",
                     $time, out_a, out_b, busy_a, busy_b, m_out, m_busy);
         end
      end
   endtask

   task automatic test_random();
      int hold;
      for (int b = 0; b < 40; b++) begin
         led_in = 8'($urandom);
         enable = ($urandom_range(0, 9) != 0);
         hold   = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 400) : $urandom_range(1, 40);
         for (int k = 0; k < hold; k++) begin
            step();
            vectors++;
            if (out_a !== m_out || out_b !== ~m_out || busy_a !== m_busy || busy_b !== m_busy) begin
               miscompares++;
               $display("FAIL random b=%0d t=%0t out_a=%h out_b=%h busy=%b%b, expected out=%h busy=%b",
                        b, $time, out_a, out_b, busy_a, busy_b, m_out, m_busy);
            end
         end
      end
      enable = 1'b1;
   endtask

   initial begin
      rst_n  = 1'b0;
      enable = 1'b1;
      led_in = '0;
      test_reset();
      test_async_reset();
      test_single_on();
      test_fade_periods();
      test_set_wins();
      test_chaser();
      test_enable();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
